sram_banked_swc: RTL and testbench

Multi-port, bank-interleaved SRAM for the switch fabric. It is the successor to the single-port sram_swc and lets several requesters (fetch, load/store, DMA) share one word-addressed memory. Words are interleaved across independently accessed banks on the low address bits. Each bank has its own round-robin arbiter with a req/gnt handshake, byte-enable writes and a registered 1-cycle read response.

---
 rtl/sram_swc_pkg.sv | 25 ++
 rtl/sram_bank_be.sv | 32 +++
 rtl/sram_banked_swc.sv | 151 +++++++++++++++
 tb/tb_sram_banked_swc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sram_swc_pkg.sv
// Shared parameters and geometry helpers for the banked switch-fabric SRAM.
package sram_swc_pkg;

  localparam int unsigned BYTE_BITS = 8;

  // A single bank uses no address bits for bank select.
  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return (num_banks <= 1) ? 0 : $clog2(num_banks);
  endfunction

  // Row index keeps at least one bit so a bank with a single row stays legal.
  function automatic int unsigned row_bits(input int unsigned addr_width,
                                           input int unsigned num_banks);
    return (addr_width > bank_bits(num_banks)) ? addr_width - bank_bits(num_banks) : 1;
  endfunction

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / BYTE_BITS;
  endfunction

  function automatic int unsigned id_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_bank_be.sv
// Single-port bank: byte-enable writes, registered read data.
module sram_bank_be
  import sram_swc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROW_W      = 8,
  parameter int unsigned BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [ROW_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ROW_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) mem[addr][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_banked_swc.sv
// Multi-port, bank-interleaved SRAM with per-bank round-robin arbitration.
module sram_banked_swc
  import sram_swc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o,
  output logic [CNT_WIDTH-1:0]             conflict_cnt_o
);

  localparam int unsigned BANK_BITS = bank_bits(NUM_BANKS);
  localparam int unsigned ROW_W     = row_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int unsigned BE_WIDTH  = be_width(DATA_WIDTH);
  localparam int unsigned ID_W      = id_bits(NUM_PORTS);
  localparam int unsigned BSEL_W    = id_bits(NUM_BANKS);

  logic [BSEL_W-1:0]     p_bank  [NUM_PORTS];
  logic [ROW_W-1:0]      p_row   [NUM_PORTS];
  logic [BE_WIDTH-1:0]   p_be    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] p_wdata [NUM_PORTS];
  logic [DATA_WIDTH-1:0] p_rdata [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];

  logic [ID_W-1:0]       rr        [NUM_BANKS];
  logic [ID_W-1:0]       bank_port [NUM_BANKS];
  logic [ID_W-1:0]       rsp_port  [NUM_BANKS];
  logic [ROW_W-1:0]      b_addr    [NUM_BANKS];
  logic [BE_WIDTH-1:0]   b_be      [NUM_BANKS];
  logic [DATA_WIDTH-1:0] b_wdata   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] b_rdata   [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_en;
  logic [NUM_BANKS-1:0]  b_we;
  logic [NUM_BANKS-1:0]  rsp_valid;
  logic                  conflict;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] a;
    assign a          = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign p_bank[p]  = BSEL_W'(a & ADDR_WIDTH'(NUM_BANKS - 1));
    assign p_row[p]   = ROW_W'(a >> BANK_BITS);
    assign p_be[p]    = be_i[p*BE_WIDTH +: BE_WIDTH];
    assign p_wdata[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = p_rdata[p];
  end

  // Per bank: count requesters for conflict detection, then pick the first
  // requester found scanning upward from the bank's round-robin pointer.
  always_comb begin
    int unsigned n_req;
    int unsigned idx;
    gnt_o    = '0;
    bank_en  = '0;
    conflict = 1'b0;
    n_req    = 0;
    idx      = 0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_port[b] = '0;
      n_req = 0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (req_i[p] && p_bank[p] == BSEL_W'(b)) n_req++;
      end
      if (n_req >= 2) conflict = 1'b1;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = (32'(rr[b]) + k) % NUM_PORTS;
        if (rst_n && !bank_en[b] && req_i[ID_W'(idx)] && p_bank[ID_W'(idx)] == BSEL_W'(b)) begin
          bank_en[b]          = 1'b1;
          bank_port[b]        = ID_W'(idx);
          gnt_o[ID_W'(idx)]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      b_we[b]    = we_i[bank_port[b]];
      b_addr[b]  = p_row[bank_port[b]];
      b_be[b]    = p_be[bank_port[b]];
      b_wdata[b] = p_wdata[bank_port[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank_be #(
      .DATA_WIDTH(DATA_WIDTH),
      .ROW_W     (ROW_W),
      .BE_WIDTH  (BE_WIDTH)
    ) u_bank (
      .clk  (clk),
      .en   (bank_en[b]),
      .we   (b_we[b]),
      .be   (b_be[b]),
      .addr (b_addr[b]),
      .wdata(b_wdata[b]),
      .rdata(b_rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= '0;
      conflict_cnt_o <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        rr[b]       <= '0;
        rsp_port[b] <= '0;
      end
    end else begin
      rsp_valid <= bank_en & ~b_we;
      if (conflict && conflict_cnt_o != '1) conflict_cnt_o <= conflict_cnt_o + 1'b1;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        rsp_port[b] <= bank_port[b];
        if (bank_en[b]) rr[b] <= ID_W'((32'(bank_port[b]) + 32'd1) % NUM_PORTS);
      end
    end
  end

  // Bank read registers are shared between ports, so each port keeps its own
  // copy of its last response to hold rdata_o between responses.
  always_comb begin
    rvalid_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) p_rdata[p] = rdata_q[p];
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (rsp_valid[b]) begin
        rvalid_o[rsp_port[b]] = 1'b1;
        p_rdata[rsp_port[b]]  = b_rdata[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= p_rdata[p];
    end
  end

endmodule

// File: tb/tb_sram_banked_swc.sv
// Directed vector bench for sram_banked_swc (2 ports, 4 banks, 32-bit words).
module tb_sram_banked_swc;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [19:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [7:0]  be;
  logic [19:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [63:0] rdata;
  logic [15:0] cnt;
  logic [1:0]  gnt_s, rvalid_s;
  logic [63:0] rdata_s;
  logic [1:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  sram_banked_swc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_PORTS(2), .NUM_BANKS(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .conflict_cnt_o(cnt)
  );

  sram_banked_swc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_PORTS(2), .NUM_BANKS(4), .CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt_s), .rvalid_o(rvalid_s), .rdata_o(rdata_s),
    .conflict_cnt_o(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one record now, let combinational paths settle, compare outputs.
  task automatic apply_check(input vec_t v, input string tag);
    req = v.req; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    #1;
    check({tag, ".gnt"},    64'(gnt),    64'(v.gnt));
    check({tag, ".rvalid"}, 64'(rvalid), 64'(v.rvalid));
    check({tag, ".rdata"},  rdata,       v.rdata);
    check({tag, ".cnt"},    64'(cnt),    64'(v.cnt));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    apply_check(v, tag);
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [7:0] b,
                              input logic [19:0] a, input logic [63:0] d, input logic [1:0] g,
                              input logic [1:0] rv, input logic [63:0] rd, input logic [15:0] c);
    vec_t v;
    v.req = r; v.we = w; v.be = b; v.addr = a; v.wdata = d;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.cnt = c;
    return v;
  endfunction

  vec_t vecs [15];
  vec_t conf;

  initial begin
    vecs[0]  = mk(2'b01, 2'b01, 8'h0F, {10'd0, 10'd5}, {32'h0, 32'h11223344}, 2'b01, 2'b00, 64'h0, 16'd0);
    vecs[1]  = mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd5}, 64'h0,                 2'b01, 2'b00, 64'h0, 16'd0);
    vecs[2]  = mk(2'b01, 2'b01, 8'h0F, {10'd0, 10'd9}, {32'h0, 32'hAAAAAAAA}, 2'b01, 2'b01, {32'h0, 32'h11223344}, 16'd0);
    vecs[3]  = mk(2'b01, 2'b01, 8'h02, {10'd0, 10'd9}, {32'h0, 32'h00005500}, 2'b01, 2'b00, {32'h0, 32'h11223344}, 16'd0);
    vecs[4]  = mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd9}, 64'h0,                 2'b01, 2'b00, {32'h0, 32'h11223344}, 16'd0);
    vecs[5]  = mk(2'b00, 2'b00, 8'h00, 20'd0,          64'h0,                 2'b00, 2'b01, {32'h0, 32'hAAAA55AA}, 16'd0);
    vecs[6]  = mk(2'b11, 2'b11, 8'hFF, {10'd1, 10'd0}, {32'h0000BEEF, 32'hCAFE0000}, 2'b11, 2'b00, {32'h0, 32'hAAAA55AA}, 16'd0);
    vecs[7]  = mk(2'b11, 2'b00, 8'h00, {10'd1, 10'd0}, 64'h0,                 2'b11, 2'b00, {32'h0, 32'hAAAA55AA}, 16'd0);
    vecs[8]  = mk(2'b00, 2'b00, 8'h00, 20'd0,          64'h0,                 2'b00, 2'b11, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[9]  = mk(2'b10, 2'b10, 8'h00, {10'd1, 10'd0}, {32'hFFFFFFFF, 32'h0}, 2'b10, 2'b00, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[10] = mk(2'b10, 2'b00, 8'h00, {10'd1, 10'd0}, 64'h0,                 2'b10, 2'b00, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[11] = mk(2'b00, 2'b00, 8'h00, 20'd0,          64'h0,                 2'b00, 2'b10, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[12] = mk(2'b01, 2'b01, 8'h0F, {10'd0, 10'd3}, {32'h0, 32'h12345678}, 2'b01, 2'b00, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[13] = mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd3}, 64'h0,                 2'b01, 2'b00, {32'h0000BEEF, 32'hCAFE0000}, 16'd0);
    vecs[14] = mk(2'b00, 2'b00, 8'h00, 20'd0,          64'h0,                 2'b00, 2'b01, {32'h0000BEEF, 32'h12345678}, 16'd0);

    // Reset state, with a request held to show gnt is suppressed in reset.
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00; be = 8'h00; addr = 20'd0; wdata = 64'h0;
    repeat (2) @(negedge clk);
    apply_check(mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd5}, 64'h0, 2'b00, 2'b00, 64'h0, 16'd0), "reset");
    check("reset.cnt_sat", 64'(cnt_s), 64'd0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Same-bank contention on bank 2: grants alternate from rr=0.
    run_vec(mk(2'b01, 2'b01, 8'h0F, {10'd0, 10'd2}, {32'h0, 32'h22222222}, 2'b01, 2'b00, {32'h0000BEEF, 32'h12345678}, 16'd0), "wr2");
    run_vec(mk(2'b10, 2'b10, 8'hF0, {10'd6, 10'd0}, {32'h66666666, 32'h0}, 2'b10, 2'b00, {32'h0000BEEF, 32'h12345678}, 16'd0), "wr6");
    conf = mk(2'b11, 2'b00, 8'h00, {10'd6, 10'd2}, 64'h0, 2'b01, 2'b00, {32'h0000BEEF, 32'h12345678}, 16'd0);
    run_vec(conf, "conf1");
    conf.gnt = 2'b10; conf.rvalid = 2'b01; conf.rdata = {32'h0000BEEF, 32'h22222222}; conf.cnt = 16'd1;
    run_vec(conf, "conf2");
    conf.gnt = 2'b01; conf.rvalid = 2'b10; conf.rdata = {32'h66666666, 32'h22222222}; conf.cnt = 16'd2;
    run_vec(conf, "conf3");
    check("conf3.cnt_sat", 64'(cnt_s), 64'd2);
    conf.gnt = 2'b10; conf.rvalid = 2'b01; conf.cnt = 16'd3;
    run_vec(conf, "conf4");
    run_vec(mk(2'b00, 2'b00, 8'h00, 20'd0, 64'h0, 2'b00, 2'b10, {32'h66666666, 32'h22222222}, 16'd4), "conf_end");
    check("conf_end.cnt_sat", 64'(cnt_s), 64'd3);

    // Async reset the cycle after a read grant: response must be dropped.
    run_vec(mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd5}, 64'h0, 2'b01, 2'b00, {32'h66666666, 32'h22222222}, 16'd4), "pre_rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.rvalid", 64'(rvalid), 64'd0);
    check("rst.gnt",    64'(gnt),    64'd0);
    check("rst.rdata",  rdata,       64'h0);
    check("rst.cnt",    64'(cnt),    64'd0);
    repeat (2) @(negedge clk);
    check("rst.rvalid_hold", 64'(rvalid), 64'd0);
    rst_n = 1'b1;

    // Re-arbitration from rr=0, six conflict cycles to saturate the 2-bit counter.
    apply_check(mk(2'b11, 2'b00, 8'h00, {10'd6, 10'd2}, 64'h0, 2'b01, 2'b00, 64'h0, 16'd0), "post_rst0");
    for (int k = 1; k <= 5; k++) begin
      conf.gnt    = (k % 2 == 1) ? 2'b10 : 2'b01;
      conf.rvalid = (k % 2 == 1) ? 2'b01 : 2'b10;
      conf.rdata  = (k == 1) ? {32'h0, 32'h22222222} : {32'h66666666, 32'h22222222};
      conf.cnt    = 16'(k);
      run_vec(conf, $sformatf("post_rst%0d", k));
      check($sformatf("post_rst%0d.cnt_sat", k), 64'(cnt_s), (k >= 3) ? 64'd3 : 64'(k));
    end
    run_vec(mk(2'b01, 2'b00, 8'h00, {10'd0, 10'd5}, 64'h0, 2'b01, 2'b10, {32'h66666666, 32'h22222222}, 16'd6), "rd5_again");
    check("sat.cnt_sat", 64'(cnt_s), 64'd3);
    run_vec(mk(2'b00, 2'b00, 8'h00, 20'd0, 64'h0, 2'b00, 2'b01, {32'h66666666, 32'h11223344}, 16'd6), "rd5_rsp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
